// File: rtl/dma_axi_arb_if.sv
// Bus bundles around the DMA arbiter: the requester-facing side and
// the DMA-native side, each with a master and a slave view.

`ifndef AXI_ADDR_W
`define AXI_ADDR_W 32
`endif
`ifndef AXI_LEN_W
`define AXI_LEN_W 8
`endif

interface dma_axi_arb_req_if #(
    parameter int N_REQ      = 2,
    parameter int DMA_DATA_W = 32,
    parameter int AXI_ADDR_W = `AXI_ADDR_W,
    parameter int AXI_LEN_W  = `AXI_LEN_W
);
    localparam int STRB_W = DMA_DATA_W / 8;

    logic [N_REQ-1:0]            req_valid;
    logic [N_REQ*AXI_ADDR_W-1:0] req_address;
    logic [N_REQ*DMA_DATA_W-1:0] req_wdata;
    logic [N_REQ*STRB_W-1:0]     req_wstrb;
    logic [N_REQ*AXI_LEN_W-1:0]  req_len;
    logic [DMA_DATA_W-1:0]       req_rdata;
    logic [N_REQ-1:0]            req_ready;

    // The requesting cores drive the request fields.
    modport master (
        output req_valid, req_address, req_wdata, req_wstrb, req_len,
        input  req_rdata, req_ready
    );

    // The arbiter consumes requests and returns data/ready.
    modport slave (
        input  req_valid, req_address, req_wdata, req_wstrb, req_len,
        output req_rdata, req_ready
    );
endinterface

interface dma_axi_arb_dma_if #(
    parameter int DMA_DATA_W = 32,
    parameter int AXI_ADDR_W = `AXI_ADDR_W,
    parameter int AXI_LEN_W  = `AXI_LEN_W
);
    localparam int STRB_W = DMA_DATA_W / 8;

    logic                  valid;
    logic [AXI_ADDR_W-1:0] address;
    logic [DMA_DATA_W-1:0] wdata;
    logic [STRB_W-1:0]     wstrb;
    logic [AXI_LEN_W-1:0]  dma_len;
    logic [DMA_DATA_W-1:0] rdata;
    logic                  ready;
    logic                  dma_ready;
    logic                  error;

    // The arbiter issues accesses toward the DMA engine.
    modport master (
        output valid, address, wdata, wstrb, dma_len,
        input  rdata, ready, dma_ready, error
    );

    // The DMA engine answers the accesses.
    modport slave (
        input  valid, address, wdata, wstrb, dma_len,
        output rdata, ready, dma_ready, error
    );
endinterface

// File: rtl/dma_axi_arb.sv
// Round-robin arbiter sharing the single DMA native port between N_REQ
// requesters. A grant is held for a whole burst (dma_len+1 beats) and
// then until the DMA reports it is idle again.

`ifndef AXI_ADDR_W
`define AXI_ADDR_W 32
`endif
`ifndef AXI_LEN_W
`define AXI_LEN_W 8
`endif

module dma_axi_arb #(
    parameter int N_REQ      = 2,
    parameter int DMA_DATA_W = 32,
    parameter int AXI_ADDR_W = `AXI_ADDR_W,
    parameter int AXI_LEN_W  = `AXI_LEN_W
) (
    input  logic                    clk,
    input  logic                    rst_n,
    dma_axi_arb_req_if.slave        req,
    dma_axi_arb_dma_if.master       dma,
    output logic [N_REQ-1:0]        grant_o,
    output logic                    busy_o,
    output logic [2:0]              err_id_o
);

    localparam int IDX_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int STRB_W = DMA_DATA_W / 8;
    localparam int CNT_W  = AXI_LEN_W + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [N_REQ-1:0]       grant_q, grant_d;
    logic [IDX_W-1:0]       gidx_q, gidx_d;
    logic [IDX_W-1:0]       rr_q, rr_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [AXI_LEN_W-1:0]   dma_len_q, dma_len_d;
    logic [2:0]             err_id_q, err_id_d;

    logic                   pick_found;
    logic [IDX_W-1:0]       pick_idx;
    logic [IDX_W-1:0]       next_rr;
    logic                   beat;

    // Round-robin scan: first requester at or after the rr pointer wins.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (!pick_found && req.req_valid[(int'(rr_q) + k) % N_REQ]) begin
                pick_found = 1'b1;
                pick_idx   = IDX_W'((int'(rr_q) + k) % N_REQ);
            end
        end
    end

    // Pointer value used when the current owner releases the port.
    always_comb begin
        next_rr = '0;
        if (gidx_q != IDX_W'(N_REQ - 1)) begin
            next_rr = gidx_q + IDX_W'(1);
        end
    end

    // Forward the owner's request to the DMA only while a burst is open.
    always_comb begin
        dma.valid     = 1'b0;
        dma.address   = '0;
        dma.wdata     = '0;
        dma.wstrb     = '0;
        req.req_ready = '0;
        req.req_rdata = '0;
        if (state_q == BURST) begin
            dma.valid     = req.req_valid[gidx_q];
            dma.address   = req.req_address[int'(gidx_q)*AXI_ADDR_W +: AXI_ADDR_W];
            dma.wdata     = req.req_wdata[int'(gidx_q)*DMA_DATA_W +: DMA_DATA_W];
            dma.wstrb     = req.req_wstrb[int'(gidx_q)*STRB_W +: STRB_W];
            req.req_rdata = dma.rdata;
            req.req_ready[gidx_q] = dma.ready;
        end
    end

    assign beat        = dma.valid & dma.ready;
    assign dma.dma_len = dma_len_q;
    assign grant_o     = grant_q;
    assign busy_o      = (state_q != IDLE);
    assign err_id_o    = err_id_q;

    // Next-state logic: arbitrate in IDLE, count beats in BURST, wait for the DMA in DRAIN.
    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        gidx_d    = gidx_q;
        rr_d      = rr_q;
        cnt_d     = cnt_q;
        dma_len_d = dma_len_q;
        err_id_d  = err_id_q;

        unique case (state_q)
            IDLE: begin
                if (dma.dma_ready && pick_found) begin
                    state_d            = BURST;
                    gidx_d             = pick_idx;
                    grant_d            = '0;
                    grant_d[pick_idx]  = 1'b1;
                    dma_len_d          = req.req_len[int'(pick_idx)*AXI_LEN_W +: AXI_LEN_W];
                    cnt_d              = '0;
                end
            end
            BURST: begin
                if (dma.error) begin
                    state_d  = IDLE;
                    err_id_d = 3'(gidx_q);
                    rr_d     = next_rr;
                    grant_d  = '0;
                end else if (beat) begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == {1'b0, dma_len_q}) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (dma.error) begin
                    state_d  = IDLE;
                    err_id_d = 3'(gidx_q);
                    rr_d     = next_rr;
                    grant_d  = '0;
                end else if (dma.dma_ready) begin
                    state_d = IDLE;
                    rr_d    = next_rr;
                    grant_d = '0;
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase
    end

    // State and bookkeeping registers; reset drops any open burst at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            grant_q   <= '0;
            gidx_q    <= '0;
            rr_q      <= '0;
            cnt_q     <= '0;
            dma_len_q <= '0;
            err_id_q  <= '0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            gidx_q    <= gidx_d;
            rr_q      <= rr_d;
            cnt_q     <= cnt_d;
            dma_len_q <= dma_len_d;
            err_id_q  <= err_id_d;
        end
    end

endmodule

// File: tb/tb_dma_axi_arb.sv
// Directed bench for the DMA round-robin arbiter. A transaction-level model
// (owner / beats remaining / rr pointer) predicts every output each cycle.

module tb_dma_axi_arb;

    localparam int N  = 2;
    localparam int DW = 32;
    localparam int AW = 32;
    localparam int LW = 8;
    localparam int SW = DW / 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    logic [N-1:0] grant;
    logic         busy;
    logic [2:0]   errId;

    int checks = 0;
    int errors = 0;
    int beatCount = 0;
    int beatBase  = 0;

    // Model state: owner -1 means nobody holds the port.
    int owner     = -1;
    int beatsLeft = 0;
    int rrPtr     = 0;
    int lenLat    = 0;
    int errIdM    = 0;

    dma_axi_arb_req_if #(.N_REQ(N), .DMA_DATA_W(DW), .AXI_ADDR_W(AW), .AXI_LEN_W(LW)) reqIf ();
    dma_axi_arb_dma_if #(.DMA_DATA_W(DW), .AXI_ADDR_W(AW), .AXI_LEN_W(LW)) dmaIf ();

    dma_axi_arb #(.N_REQ(N), .DMA_DATA_W(DW), .AXI_ADDR_W(AW), .AXI_LEN_W(LW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (reqIf),
        .dma      (dmaIf),
        .grant_o  (grant),
        .busy_o   (busy),
        .err_id_o (errId)
    );

    always #5 clk = ~clk;

    // Compare one observed value with its expectation.
    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one requester's request fields.
    task automatic applyStimulus(input int i, input bit v, input logic [AW-1:0] addr,
                                 input logic [DW-1:0] data, input logic [SW-1:0] strb,
                                 input logic [LW-1:0] len);
        reqIf.req_valid[i]             = v;
        reqIf.req_address[i*AW +: AW]  = addr;
        reqIf.req_wdata[i*DW +: DW]    = data;
        reqIf.req_wstrb[i*SW +: SW]    = strb;
        reqIf.req_len[i*LW +: LW]      = len;
    endtask

    task automatic doReset();
        rst_n = 1'b0;
        reqIf.req_valid   = '0;
        reqIf.req_address = '0;
        reqIf.req_wdata   = '0;
        reqIf.req_wstrb   = '0;
        reqIf.req_len     = '0;
        dmaIf.rdata       = 32'h1234_5678;
        dmaIf.ready       = 1'b1;
        dmaIf.dma_ready   = 1'b1;
        dmaIf.error       = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        beatBase = beatCount;
    endtask

    // Wait (bounded) until grant shows the expected pattern; a timeout is a failed check.
    task automatic waitGrant(input logic [N-1:0] exp, input string name);
        bit seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (grant === exp) seen = 1'b1;
        end
        checkOutput(name, grant, exp);
    endtask

    // Wait (bounded) until the given number of beats has been forwarded since beatBase.
    task automatic waitBeats(input int target);
        bit done = 1'b0;
        for (int i = 0; i < 80 && !done; i++) begin
            @(negedge clk);
            #1;
            if (beatCount - beatBase >= target) done = 1'b1;
        end
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    // Count forwarded beats in mid-cycle, when inputs and outputs are settled.
    always @(negedge clk) begin
        if (rst_n && dmaIf.valid && dmaIf.ready) beatCount++;
    end

    // Transaction-level model of ownership, advanced on each rising edge.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner = -1; beatsLeft = 0; rrPtr = 0; lenLat = 0; errIdM = 0;
        end else if (owner < 0) begin
            if (dmaIf.dma_ready && (|reqIf.req_valid)) begin
                for (int k = 0; k < N; k++) begin
                    if (owner < 0 && reqIf.req_valid[(rrPtr + k) % N]) owner = (rrPtr + k) % N;
                end
                lenLat    = int'(reqIf.req_len[owner*LW +: LW]);
                beatsLeft = lenLat + 1;
            end
        end else if (dmaIf.error) begin
            errIdM = owner; rrPtr = (owner + 1) % N; owner = -1; beatsLeft = 0;
        end else if (beatsLeft > 0) begin
            if (reqIf.req_valid[owner] && dmaIf.ready) beatsLeft--;
        end else if (dmaIf.dma_ready) begin
            rrPtr = (owner + 1) % N; owner = -1;
        end
    end

    // Every cycle: all outputs against the model.
    always @(negedge clk) begin : compareProc
        int o;
        bit inB;
        logic [N-1:0] expRdy;
        logic [N-1:0] expGnt;
        o      = (owner < 0) ? 0 : owner;
        inB    = (owner >= 0) && (beatsLeft > 0);
        expRdy = '0;
        expGnt = '0;
        if (inB && dmaIf.ready) expRdy[o] = 1'b1;
        if (owner >= 0) expGnt[o] = 1'b1;
        checkOutput("valid",     64'(dmaIf.valid),   64'(inB && reqIf.req_valid[o]));
        checkOutput("address",   64'(dmaIf.address), inB ? 64'(reqIf.req_address[o*AW +: AW]) : 64'd0);
        checkOutput("wdata",     64'(dmaIf.wdata),   inB ? 64'(reqIf.req_wdata[o*DW +: DW]) : 64'd0);
        checkOutput("wstrb",     64'(dmaIf.wstrb),   inB ? 64'(reqIf.req_wstrb[o*SW +: SW]) : 64'd0);
        checkOutput("req_rdata", 64'(reqIf.req_rdata), inB ? 64'(dmaIf.rdata) : 64'd0);
        checkOutput("req_ready", 64'(reqIf.req_ready), 64'(expRdy));
        checkOutput("grant",     64'(grant),         64'(expGnt));
        checkOutput("busy",      64'(busy),          64'(owner >= 0));
        checkOutput("dma_len",   64'(dmaIf.dma_len), 64'(lenLat));
        checkOutput("err_id",    64'(errId),         64'(errIdM));
    end

    initial begin
        $display("[TB] start");
        doReset();
        @(negedge clk);
        checkOutput("reset_grant", grant, 0);
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_dma_len", dmaIf.dma_len, 0);
        checkOutput("reset_err_id", errId, 0);

        // Test 1: single requester, len 3, four beats, DRAIN held until dma_ready.
        nextCycle();
        beatBase = beatCount;
        applyStimulus(0, 1, 32'h0000_1000, 32'hA5A5_0001, 4'hF, 8'd3);
        waitGrant(2'b01, "t1_grant");
        nextCycle();
        dmaIf.dma_ready = 1'b0;
        waitBeats(4);
        nextCycle();
        applyStimulus(0, 0, 32'h0000_1000, 32'hA5A5_0001, 4'hF, 8'd3);
        repeat (3) @(negedge clk);
        checkOutput("t1_beats", 64'(beatCount - beatBase), 4);
        checkOutput("t1_drain_grant", grant, 2'b01);
        checkOutput("t1_dma_len", dmaIf.dma_len, 3);
        nextCycle();
        dmaIf.dma_ready = 1'b1;
        waitGrant(2'b00, "t1_release");
        // rr now points at requester 1.
        nextCycle();
        applyStimulus(0, 1, 32'h0000_1100, 32'h1, 4'h1, 8'd0);
        applyStimulus(1, 1, 32'h0000_2000, 32'h2, 4'h3, 8'd0);
        waitGrant(2'b10, "t1_rr_next");
        nextCycle();
        applyStimulus(0, 0, 32'h0, 32'h0, 4'h0, 8'd0);
        applyStimulus(1, 0, 32'h0, 32'h0, 4'h0, 8'd0);
        waitGrant(2'b00, "t1b_release");

        // Test 2: simultaneous requests with rr=0, req0 first then req1.
        doReset();
        applyStimulus(0, 1, 32'h0000_3000, 32'hDEAD_0000, 4'hF, 8'd1);
        applyStimulus(1, 1, 32'h0000_3100, 32'hBEEF_0000, 4'hC, 8'd1);
        waitGrant(2'b01, "t2_first");
        waitBeats(2);
        nextCycle();
        applyStimulus(0, 0, 32'h0000_3000, 32'hDEAD_0000, 4'hF, 8'd1);
        waitGrant(2'b10, "t2_second");
        checkOutput("t2_dma_len", dmaIf.dma_len, 1);
        waitBeats(4);
        nextCycle();
        applyStimulus(1, 0, 32'h0000_3100, 32'hBEEF_0000, 4'hC, 8'd1);
        waitGrant(2'b00, "t2_release");

        // Test 3: single-beat read, rdata returned, nothing forwarded in DRAIN.
        doReset();
        dmaIf.rdata = 32'hCAFE_F00D;
        applyStimulus(0, 1, 32'h0000_4000, 32'h0, 4'h0, 8'd0);
        waitGrant(2'b01, "t3_grant");
        checkOutput("t3_rdata", reqIf.req_rdata, 32'hCAFE_F00D);
        checkOutput("t3_req_ready", reqIf.req_ready, 2'b01);
        checkOutput("t3_wstrb", dmaIf.wstrb, 0);
        nextCycle();
        dmaIf.dma_ready = 1'b0;
        @(negedge clk);
        checkOutput("t3_drain_valid", dmaIf.valid, 0);
        checkOutput("t3_drain_ready", reqIf.req_ready, 0);
        checkOutput("t3_beats", 64'(beatCount - beatBase), 1);
        nextCycle();
        applyStimulus(0, 0, 32'h0, 32'h0, 4'h0, 8'd0);
        dmaIf.dma_ready = 1'b1;
        waitGrant(2'b00, "t3_release");

        // Test 4: owner stalls 5 cycles mid-burst, keeps grant; late len change ignored.
        doReset();
        applyStimulus(0, 1, 32'h0000_5000, 32'h5555_0000, 4'hF, 8'd7);
        applyStimulus(1, 1, 32'h0000_6000, 32'h6666_0000, 4'hF, 8'd2);
        waitGrant(2'b01, "t4_grant");
        waitBeats(3);
        nextCycle();
        applyStimulus(0, 0, 32'h0000_5000, 32'h5555_0000, 4'hF, 8'd1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checkOutput("t4_hold_grant", grant, 2'b01);
            @(posedge clk);
        end
        #1 applyStimulus(0, 1, 32'h0000_5000, 32'h5555_0000, 4'hF, 8'd1);
        waitBeats(8);
        nextCycle();
        applyStimulus(0, 0, 32'h0000_5000, 32'h5555_0000, 4'hF, 8'd1);
        @(negedge clk);
        checkOutput("t4_beats", 64'(beatCount - beatBase), 8);
        checkOutput("t4_dma_len", dmaIf.dma_len, 7);
        waitGrant(2'b10, "t4_fair");
        waitBeats(11);
        nextCycle();
        applyStimulus(1, 0, 32'h0000_6000, 32'h6666_0000, 4'hF, 8'd2);
        waitGrant(2'b00, "t4_release");

        // Test 5: error during requester 1's burst.
        doReset();
        applyStimulus(1, 1, 32'h0000_7000, 32'h7777_0000, 4'hF, 8'd5);
        waitGrant(2'b10, "t5_grant");
        nextCycle();
        applyStimulus(0, 1, 32'h0000_7100, 32'h7100_0000, 4'hF, 8'd0);
        dmaIf.error = 1'b1;
        nextCycle();
        dmaIf.error = 1'b0;
        @(negedge clk);
        checkOutput("t5_grant_cleared", grant, 2'b00);
        checkOutput("t5_idle", busy, 0);
        checkOutput("t5_err_id", errId, 1);
        waitGrant(2'b01, "t5_next_req0");
        nextCycle();
        applyStimulus(0, 0, 32'h0, 32'h0, 4'h0, 8'd0);
        applyStimulus(1, 0, 32'h0, 32'h0, 4'h0, 8'd0);
        waitGrant(2'b00, "t5_release");

        // Test 6: async reset mid-burst clears the rr pointer as well.
        doReset();
        applyStimulus(0, 1, 32'h0000_8000, 32'h8, 4'hF, 8'd0);
        waitGrant(2'b01, "t6_warmup");
        nextCycle();
        applyStimulus(0, 0, 32'h0, 32'h0, 4'h0, 8'd0);
        waitGrant(2'b00, "t6_warmup_release");
        nextCycle();
        applyStimulus(0, 1, 32'h0000_8100, 32'h81, 4'hF, 8'd7);
        waitGrant(2'b01, "t6_grant");
        nextCycle();
        applyStimulus(1, 1, 32'h0000_8200, 32'h82, 4'hF, 8'd0);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("t6_rst_grant", grant, 0);
        checkOutput("t6_rst_busy", busy, 0);
        checkOutput("t6_rst_valid", dmaIf.valid, 0);
        checkOutput("t6_rst_req_ready", reqIf.req_ready, 0);
        checkOutput("t6_rst_address", dmaIf.address, 0);
        checkOutput("t6_rst_dma_len", dmaIf.dma_len, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        waitGrant(2'b01, "t6_after_reset");
        nextCycle();
        applyStimulus(0, 0, 32'h0, 32'h0, 4'h0, 8'd0);
        applyStimulus(1, 0, 32'h0, 32'h0, 4'h0, 8'd0);
        repeat (2) @(posedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
